// File: rtl/pacman_pkg.sv
// Shared definitions for the score display path: converter state encoding
// and active-low seven-segment patterns (bit order gfedcba).
package pacman_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_decoder.sv
// One BCD digit to an active-low seven-segment pattern; codes above 9 blank the display.
module hex_decoder
    import pacman_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Serial double-dabble binary-to-BCD converter for the score display, one bit per clock,
// with a registered result driving six seven-segment digits and an overflow flag.
//   state    | meaning
//   ST_IDLE  | waiting for start; score sampled on acceptance
//   ST_SHIFT | one add-3/shift iteration per clock, WIDTH iterations
//   ST_DONE  | bcd just updated; done high for this single cycle
module score_bcd_converter
    import pacman_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      score,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic [6:0]            hex4,
    output logic [6:0]            hex5
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;

    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_sh;
    logic [WIDTH-1:0]   bin_sh;

    // Per-digit add-3 is confined to 4 bits; no carry crosses digit boundaries.
    always_comb begin
        scr_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            scr_adj[4*i +: 4] = scr_q[4*i +: 4] + ((scr_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    assign scr_sh = {scr_adj[BCD_W-2:0], bin_q[WIDTH-1]};
    assign bin_sh = {bin_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = score;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_d = bin_sh;
                scr_d = scr_sh;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_sh;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign bcd  = bcd_q;

    // Display and overflow look only at the committed result, never the scratch.
    generate
        if (DIGITS > 6) begin : g_ovf
            assign overflow = |bcd_q[BCD_W-1:24];
        end else begin : g_no_ovf
            assign overflow = 1'b0;
        end
    endgenerate

    hex_decoder u_hex0 (.digit_i(bcd_q[3:0]),   .seg_o(hex0));
    hex_decoder u_hex1 (.digit_i(bcd_q[7:4]),   .seg_o(hex1));
    hex_decoder u_hex2 (.digit_i(bcd_q[11:8]),  .seg_o(hex2));
    hex_decoder u_hex3 (.digit_i(bcd_q[15:12]), .seg_o(hex3));
    hex_decoder u_hex4 (.digit_i(bcd_q[19:16]), .seg_o(hex4));
    hex_decoder u_hex5 (.digit_i(bcd_q[23:20]), .seg_o(hex5));

endmodule
